// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared types and width helpers for the pending priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

  // Arbitration policy: fixed (highest index wins) or round-robin.
  typedef enum logic {
    PE_FIXED = 1'b0,
    PE_RR    = 1'b1
  } pe_mode_e;

  // Width of a binary index into n request lines.
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // Width able to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_select.sv
`default_nettype none
// ============================================================================
// Module   : pe_select
// Purpose  : Combinational winner selection over the candidate set.
// Revision : 1.0 - initial release
// ============================================================================
module pe_select
  import pe_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  input  pe_mode_e     mode,
  output logic [W-1:0] idx,
  output logic         found
);

  // Fixed: last hit in an upward scan is the highest index.
  // Round-robin: scan downward over offsets so the smallest offset from ptr+1 wins.
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = |cand;
    if (mode == PE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) idx = W'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (cand[j]) idx = W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pending_priority_encoder
// Purpose  : Latches one-cycle request pulses and grants them one per cycle
//            through a valid/ready output stage, fixed or round-robin order.
// Revision : 1.0 - initial release
// ============================================================================
module pending_priority_encoder
  import pe_pkg::*;
#(
  parameter int       N    = 8,
  parameter pe_mode_e MODE = PE_FIXED,
  localparam int      W    = idx_width(N),
  localparam int      CW   = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic          clr,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_idx,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] count,
  output logic          dup_err
);

  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  logic [N-1:0]  pending_q, pending_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  idx_q, idx_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic          dup_q, dup_d;
  logic [N-1:0]  cand;
  logic [W-1:0]  sel_idx;
  logic          sel_found;
  logic          can_load;
  logic [CW-1:0] count_w;

  // Arrivals are grantable in the same cycle they show up.
  assign cand     = pending_q | req_in;
  assign can_load = !valid_q || out_ready;

  pe_select #(
    .N (N),
    .W (W)
  ) u_select (
    .cand  (cand),
    .ptr   (ptr_q),
    .mode  (MODE),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Next-state: clr dominates, otherwise load/idle/hold the output stage.
  always_comb begin
    pending_d = cand;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    dup_d     = dup_q | (|(req_in & pending_q));
    if (clr) begin
      pending_d = '0;
      valid_d   = 1'b0;
      idx_d     = '0;
      dup_d     = 1'b0;
    end else if (can_load) begin
      if (sel_found) begin
        valid_d = 1'b1;
        idx_d   = sel_idx;
        ptr_d   = sel_idx;
        for (int i = 0; i < N; i++) begin
          if (W'(i) == sel_idx) pending_d[i] = 1'b0;
        end
      end else begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end
  end

  // State registers; reset parks ptr at N-1 so the first RR scan starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= PTR_RST;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      dup_q     <= dup_d;
    end
  end

  // Popcount of the registered pending set.
  always_comb begin
    count_w = '0;
    for (int i = 0; i < N; i++) begin
      count_w = count_w + CW'(pending_q[i]);
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign count     = count_w;
  assign dup_err   = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_pending_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pending_priority_encoder
// Purpose  : Directed self-checking bench for pending_priority_encoder
//            (N=8 fixed, N=8 round-robin, N=5 round-robin instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pending_priority_encoder;
  import pe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b1;

  logic [7:0] req_a = '0, req_b = '0;
  logic [4:0] req_c = '0;

  logic       va, vb, vc;
  logic [2:0] ia, ib, ic;
  logic [7:0] pa, pb;
  logic [4:0] pc;
  logic [3:0] ca, cb;
  logic [2:0] cc;
  logic       da, db, dc;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pending_priority_encoder #(.N(8), .MODE(PE_FIXED)) u_a (
    .clk(clk), .rst_n(rst_n), .req_in(req_a), .clr(clr), .out_ready(out_ready),
    .out_valid(va), .out_idx(ia), .pending(pa), .count(ca), .dup_err(da));

  pending_priority_encoder #(.N(8), .MODE(PE_RR)) u_b (
    .clk(clk), .rst_n(rst_n), .req_in(req_b), .clr(clr), .out_ready(out_ready),
    .out_valid(vb), .out_idx(ib), .pending(pb), .count(cb), .dup_err(db));

  pending_priority_encoder #(.N(5), .MODE(PE_RR)) u_c (
    .clk(clk), .rst_n(rst_n), .req_in(req_c), .clr(clr), .out_ready(out_ready),
    .out_valid(vc), .out_idx(ic), .pending(pc), .count(cc), .dup_err(dc));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected grant; an empty queue means the stage must be idle.
  task automatic sb_check(input string tag, input logic v, input logic [2:0] idx);
    int e;
    if (exp_q.size() == 0) begin
      chk({tag, "_valid0"}, 64'(v), 64'd0);
      chk({tag, "_idx0"}, 64'(idx), 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(v), 64'd1);
      chk({tag, "_idx"}, 64'(idx), 64'(e));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", 64'(va), 64'd0);
    chk("rst_idx", 64'(ia), 64'd0);
    chk("rst_pending", 64'(pa), 64'd0);
    chk("rst_count", 64'(ca), 64'd0);
    chk("rst_dup", 64'(da), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fixed priority drain of 1001_0010
    out_ready = 1'b1;
    req_a = 8'b1001_0010;
    exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(1);
    tick();
    req_a = '0;
    sb_check("fix_g0", va, ia); chk("fix_cnt0", 64'(ca), 64'd2);
    tick();
    sb_check("fix_g1", va, ia); chk("fix_cnt1", 64'(ca), 64'd1);
    tick();
    sb_check("fix_g2", va, ia); chk("fix_cnt2", 64'(ca), 64'd0);
    tick();
    sb_check("fix_idle", va, ia);

    // Round-robin with all requests held ten cycles
    for (int t = 0; t < 10; t++) exp_q.push_back(t % 8);
    for (int t = 0; t < 10; t++) begin
      req_b = 8'hFF;
      tick();
      sb_check("rr_g", vb, ib);
      chk("rr_dup", 64'(db), (t >= 1) ? 64'd1 : 64'd0);
    end
    req_b = '0;
    // Leftovers after grant of 1: search resumes at 2 and wraps to 0
    for (int t = 2; t < 8; t++) exp_q.push_back(t);
    exp_q.push_back(0);
    for (int t = 0; t < 7; t++) begin
      tick();
      sb_check("rr_drain", vb, ib);
    end
    tick();
    sb_check("rr_idle", vb, ib);
    chk("rr_dup_sticky", 64'(db), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rr_dup_clr", 64'(db), 64'd0);

    // Back-pressure: stage holds 2, bit 0 stays pending
    out_ready = 1'b0;
    req_a = 8'h05;
    tick();
    req_a = '0;
    chk("bp_idx", 64'(ia), 64'd2);
    chk("bp_pend", 64'(pa), 64'h01);
    chk("bp_cnt", 64'(ca), 64'd1);
    tick();
    chk("bp_hold_idx", 64'(ia), 64'd2);
    chk("bp_hold_v", 64'(va), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_next", 64'(ia), 64'd0);
    chk("bp_next_v", 64'(va), 64'd1);
    tick();
    chk("bp_idle", 64'(va), 64'd0);

    // clr while holding idx 3 with bit 6 pending and dup_err set
    out_ready = 1'b0;
    req_a = 8'h08;
    tick();
    req_a = 8'h40;
    tick();
    chk("clr_pre_idx", 64'(ia), 64'd3);
    chk("clr_pre_pend", 64'(pa), 64'h40);
    chk("clr_pre_dup0", 64'(da), 64'd0);
    tick();
    req_a = '0;
    chk("clr_pre_dup1", 64'(da), 64'd1);
    clr = 1'b1;
    req_a = 8'h01;
    tick();
    clr = 1'b0;
    req_a = '0;
    chk("clr_valid", 64'(va), 64'd0);
    chk("clr_idx", 64'(ia), 64'd0);
    chk("clr_pend", 64'(pa), 64'd0);
    chk("clr_dup", 64'(da), 64'd0);
    chk("clr_cnt", 64'(ca), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("clr_discard", 64'(va), 64'd0);

    // Request for the held index is a new pending request, not a duplicate
    out_ready = 1'b0;
    req_a = 8'h08;
    tick();
    req_a = 8'hF8;
    tick();
    req_a = '0;
    chk("held_pend", 64'(pa), 64'hF8);
    chk("held_dup", 64'(da), 64'd0);
    chk("held_v", 64'(va), 64'd1);

    // Asynchronous reset mid-stream
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(va), 64'd0);
    chk("arst_idx", 64'(ia), 64'd0);
    chk("arst_pend", 64'(pa), 64'd0);
    chk("arst_cnt", 64'(ca), 64'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    req_a = 8'h08;
    tick();
    req_a = '0;
    chk("arst_after", 64'(ia), 64'd3);
    chk("arst_after_v", 64'(va), 64'd1);

    // N=5 round-robin wrap
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(4);
    req_c = 5'b10001;
    tick();
    req_c = '0;
    sb_check("n5_g0", vc, ic);
    tick();
    sb_check("n5_g1", vc, ic);
    req_c = 5'b10001;
    tick();
    req_c = '0;
    sb_check("n5_g2", vc, ic);
    tick();
    sb_check("n5_g3", vc, ic);
    tick();
    sb_check("n5_idle", vc, ic);
    chk("n5_cnt", 64'(cc), 64'd0);
    chk("n5_dup", 64'(dc), 64'd0);
    chk("n5_pend", 64'(pc), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
